// File: rtl/v_lsu_ctrl_if.sv
// Decode-side request/response channel of the vector LSU sequencer.
// Decode is the master; the sequencer is the slave.
interface v_lsu_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [2:0]        req_lmul;
    logic [2:0]        req_vsew;
    logic [4:0]        req_stride;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_vd;
    logic              rsp_valid;
    logic [1:0]        rsp_err;
    logic [4:0]        rsp_vd;

    modport master (
        output req_valid, req_op, req_lmul, req_vsew, req_stride, req_addr, req_vd,
        input  req_ready, rsp_valid, rsp_err, rsp_vd
    );

    modport slave (
        input  req_valid, req_op, req_lmul, req_vsew, req_stride, req_addr, req_vd,
        output req_ready, rsp_valid, rsp_err, rsp_vd
    );
endinterface

// File: rtl/v_lsu_ctrl.sv
// Vector LSU sequencer: one pending request slot, legality check, load/store unit start,
// bank ownership, watchdog-guarded wait for done, in-order response.
module v_lsu_ctrl #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              nrst,
    v_lsu_ctrl_if.slave       dec,
    output logic              ld_start,
    output logic              st_start,
    output logic              unit_abort,
    output logic [3:0]        unit_op,
    output logic [2:0]        unit_lmul,
    output logic [2:0]        unit_vsew,
    output logic [4:0]        unit_stride,
    output logic [ADDR_W-1:0] unit_addr,
    input  logic              ld_done,
    input  logic              st_done,
    output logic              mem_sel,
    output logic              mem_we,
    output logic              busy
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state, state_nxt;
    logic              pend_valid;
    logic [3:0]        pend_op;
    logic [2:0]        pend_lmul;
    logic [2:0]        pend_vsew;
    logic [4:0]        pend_stride;
    logic [ADDR_W-1:0] pend_addr;
    logic [4:0]        pend_vd;
    logic              act_store;
    logic [4:0]        act_vd;
    logic [1:0]        err, err_nxt;
    logic [WD_W-1:0]   wd;
    logic              wd_clr, wd_inc;
    logic              pop, accept, done_match, pend_legal;

    // Element width encoded by the op must agree with vsew; lmul above 3 is reserved.
    function automatic logic is_legal(input logic [3:0] op, input logic [2:0] lmul,
                                      input logic [2:0] vsew);
        logic [2:0] w;
        case (op)
            4'd1, 4'd4, 4'd7, 4'd10: w = 3'b000;
            4'd2, 4'd5, 4'd8, 4'd11: w = 3'b001;
            4'd3, 4'd6, 4'd9, 4'd12: w = 3'b010;
            default:                 w = 3'b111;
        endcase
        return (w != 3'b111) && (w == vsew) && (lmul <= 3'd3);
    endfunction

    assign pend_legal    = is_legal(pend_op, pend_lmul, pend_vsew);
    assign dec.req_ready = !pend_valid;
    assign accept        = dec.req_valid && !pend_valid;
    assign done_match    = act_store ? st_done : ld_done;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = err;
        pop        = 1'b0;
        ld_start   = 1'b0;
        st_start   = 1'b0;
        unit_abort = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend_valid) begin
                    pop = 1'b1;
                    if (pend_legal) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        state_nxt = S_RESP;
                        err_nxt   = 2'b01;
                    end
                end
            end
            S_ISSUE: begin
                ld_start = !act_store;
                st_start = act_store;
                wd_clr   = 1'b1;
                if (done_match) begin
                    state_nxt = S_RESP;
                    err_nxt   = 2'b00;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_match) begin
                    state_nxt = S_RESP;
                    err_nxt   = 2'b00;
                end else if (wd == WD_LAST) begin
                    unit_abort = 1'b1;
                    state_nxt  = S_RESP;
                    err_nxt    = 2'b10;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_valid  <= 1'b0;
            pend_op     <= '0;
            pend_lmul   <= '0;
            pend_vsew   <= '0;
            pend_stride <= '0;
            pend_addr   <= '0;
            pend_vd     <= '0;
        end else if (accept) begin
            pend_valid  <= 1'b1;
            pend_op     <= dec.req_op;
            pend_lmul   <= dec.req_lmul;
            pend_vsew   <= dec.req_vsew;
            pend_stride <= dec.req_stride;
            pend_addr   <= dec.req_addr;
            pend_vd     <= dec.req_vd;
        end else if (pop) begin
            pend_valid  <= 1'b0;
        end
    end

    // Active fields only change on a pop, so unit_* hold their values between ops.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            unit_op     <= '0;
            unit_lmul   <= '0;
            unit_vsew   <= '0;
            unit_stride <= '0;
            unit_addr   <= '0;
            act_vd      <= '0;
            act_store   <= 1'b0;
        end else if (pop) begin
            unit_op     <= pend_op;
            unit_lmul   <= pend_lmul;
            unit_vsew   <= pend_vsew;
            unit_stride <= pend_stride;
            unit_addr   <= pend_addr;
            act_vd      <= pend_vd;
            act_store   <= (pend_op >= 4'd7);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err <= '0;
            wd  <= '0;
        end else begin
            err <= err_nxt;
            if (wd_clr)      wd <= '0;
            else if (wd_inc) wd <= wd + 1'b1;
        end
    end

    assign mem_sel       = ((state == S_ISSUE) || (state == S_WAIT)) && act_store;
    assign mem_we        = mem_sel;
    assign dec.rsp_valid = (state == S_RESP);
    assign dec.rsp_err   = (state == S_RESP) ? err : 2'b00;
    assign dec.rsp_vd    = (state == S_RESP) ? act_vd : 5'd0;
    assign busy          = (state != S_IDLE) || pend_valid;
endmodule

// File: tb/tb_v_lsu_ctrl.sv
// Directed bench for v_lsu_ctrl with a short watchdog (TIMEOUT_CYC = 8).
module tb_v_lsu_ctrl;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        ld_start, st_start, unit_abort;
    logic [3:0]  unit_op;
    logic [2:0]  unit_lmul, unit_vsew;
    logic [4:0]  unit_stride;
    logic [11:0] unit_addr;
    logic        ld_done = 1'b0;
    logic        st_done = 1'b0;
    logic        mem_sel, mem_we, busy;
    int          total = 0;
    int          bad = 0;

    v_lsu_ctrl_if #(.ADDR_W(12)) dec ();

    v_lsu_ctrl #(.ADDR_W(12), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .nrst(nrst), .dec(dec),
        .ld_start(ld_start), .st_start(st_start), .unit_abort(unit_abort),
        .unit_op(unit_op), .unit_lmul(unit_lmul), .unit_vsew(unit_vsew),
        .unit_stride(unit_stride), .unit_addr(unit_addr),
        .ld_done(ld_done), .st_done(st_done),
        .mem_sel(mem_sel), .mem_we(mem_we), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for exactly one edge; the slot must be free at that point.
    task automatic send(input logic [3:0] op, input logic [2:0] lmul, input logic [2:0] vsew,
                        input logic [4:0] stride, input logic [11:0] addr, input logic [4:0] vd);
        dec.req_op     = op;
        dec.req_lmul   = lmul;
        dec.req_vsew   = vsew;
        dec.req_stride = stride;
        dec.req_addr   = addr;
        dec.req_vd     = vd;
        dec.req_valid  = 1'b1;
        check("send_ready", 32'(dec.req_ready), 32'd1);
        step();
        dec.req_valid  = 1'b0;
    endtask

    initial begin
        dec.req_valid = 1'b0;
        dec.req_op = '0; dec.req_lmul = '0; dec.req_vsew = '0;
        dec.req_stride = '0; dec.req_addr = '0; dec.req_vd = '0;
        step(); step();
        check("rst_ready", 32'(dec.req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp", 32'(dec.rsp_valid), 32'd0);
        check("rst_start", 32'({ld_start, st_start, unit_abort}), 32'd0);
        check("rst_mem", 32'({mem_sel, mem_we}), 32'd0);
        check("rst_unit_op", 32'(unit_op), 32'd0);
        nrst = 1'b1;
        step();

        // 1: vse32, st_done three cycles after st_start
        send(4'd9, 3'd0, 3'b010, 5'd0, 12'h000, 5'd3);
        check("t1_acc_busy", 32'(busy), 32'd1);
        check("t1_acc_ready", 32'(dec.req_ready), 32'd0);
        check("t1_acc_start", 32'(st_start), 32'd0);
        step();
        check("t1_st_start", 32'(st_start), 32'd1);
        check("t1_ld_start", 32'(ld_start), 32'd0);
        check("t1_mem_issue", 32'({mem_sel, mem_we}), 32'h3);
        check("t1_unit_op", 32'(unit_op), 32'd9);
        check("t1_ready_pop", 32'(dec.req_ready), 32'd1);
        step();
        check("t1_st_start_w", 32'(st_start), 32'd0);
        check("t1_mem_w1", 32'({mem_sel, mem_we}), 32'h3);
        step();
        check("t1_mem_w2", 32'({mem_sel, mem_we}), 32'h3);
        step();
        check("t1_mem_w3", 32'({mem_sel, mem_we}), 32'h3);
        check("t1_no_rsp", 32'(dec.rsp_valid), 32'd0);
        st_done = 1'b1;
        step();
        st_done = 1'b0;
        check("t1_rsp_valid", 32'(dec.rsp_valid), 32'd1);
        check("t1_rsp_err", 32'(dec.rsp_err), 32'd0);
        check("t1_rsp_vd", 32'(dec.rsp_vd), 32'd3);
        check("t1_mem_resp", 32'({mem_sel, mem_we}), 32'd0);
        step();
        check("t1_idle_rsp", 32'(dec.rsp_valid), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_unit_hold", 32'(unit_op), 32'd9);

        // 2: width mismatch is illegal
        send(4'd9, 3'd0, 3'b000, 5'd0, 12'h010, 5'd5);
        check("t2_acc_start", 32'({ld_start, st_start}), 32'd0);
        step();
        check("t2_rsp_valid", 32'(dec.rsp_valid), 32'd1);
        check("t2_rsp_err", 32'(dec.rsp_err), 32'd1);
        check("t2_rsp_vd", 32'(dec.rsp_vd), 32'd5);
        check("t2_start", 32'({ld_start, st_start}), 32'd0);
        check("t2_mem_we", 32'(mem_we), 32'd0);
        step();
        check("t2_idle", 32'({dec.rsp_valid, busy, mem_we, st_start}), 32'd0);

        // lmul above 3 and op outside 1..12 are illegal
        send(4'd1, 3'd4, 3'b000, 5'd0, 12'h000, 5'd1);
        step();
        check("lmul4_err", 32'({dec.rsp_valid, dec.rsp_err}), 32'h5);
        step();
        send(4'd13, 3'd0, 3'b010, 5'd0, 12'h000, 5'd2);
        step();
        check("op13_err", 32'({dec.rsp_valid, dec.rsp_err}), 32'h5);
        check("op13_start", 32'({ld_start, st_start}), 32'd0);
        step();
        send(4'd0, 3'd0, 3'b000, 5'd0, 12'h000, 5'd2);
        step();
        check("op0_err", 32'({dec.rsp_valid, dec.rsp_err}), 32'h5);
        step();

        // 3: load in flight, store queued behind it
        send(4'd3, 3'd1, 3'b010, 5'd0, 12'h040, 5'd7);
        step();
        check("t3_ld_start", 32'(ld_start), 32'd1);
        check("t3_ld_mem_sel", 32'({mem_sel, mem_we}), 32'd0);
        check("t3_ld_addr", 32'(unit_addr), 32'h040);
        send(4'd9, 3'd0, 3'b010, 5'd0, 12'h080, 5'd8);
        check("t3_ready_full", 32'(dec.req_ready), 32'd0);
        check("t3_ld_start_w", 32'(ld_start), 32'd0);
        step();
        check("t3_ready_w", 32'(dec.req_ready), 32'd0);
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        check("t3_rsp1", 32'({dec.rsp_valid, dec.rsp_err, dec.rsp_vd}), 32'({1'b1, 2'b00, 5'd7}));
        check("t3_ready_resp", 32'(dec.req_ready), 32'd0);
        check("t3_no_st_resp", 32'(st_start), 32'd0);
        step();
        check("t3_idle_no_rsp", 32'(dec.rsp_valid), 32'd0);
        check("t3_idle_no_st", 32'(st_start), 32'd0);
        check("t3_idle_ready", 32'(dec.req_ready), 32'd0);
        check("t3_idle_busy", 32'(busy), 32'd1);
        step();
        check("t3_st_start", 32'(st_start), 32'd1);
        check("t3_ready_after_pop", 32'(dec.req_ready), 32'd1);
        check("t3_st_op", 32'(unit_op), 32'd9);
        check("t3_st_addr", 32'(unit_addr), 32'h080);
        check("t3_st_mem", 32'({mem_sel, mem_we}), 32'h3);
        step();
        st_done = 1'b1;
        step();
        st_done = 1'b0;
        check("t3_rsp2", 32'({dec.rsp_valid, dec.rsp_err, dec.rsp_vd}), 32'({1'b1, 2'b00, 5'd8}));
        step();

        // 4: strided load with no done hits the watchdog
        send(4'd6, 3'd0, 3'b010, 5'd4, 12'h100, 5'd9);
        step();
        check("t4_ld_start", 32'(ld_start), 32'd1);
        check("t4_stride", 32'(unit_stride), 32'd4);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t4_abort_w%0d", i), 32'(unit_abort), (i == 7) ? 32'd1 : 32'd0);
            check($sformatf("t4_rsp_w%0d", i), 32'(dec.rsp_valid), 32'd0);
        end
        step();
        check("t4_rsp", 32'({dec.rsp_valid, dec.rsp_err, dec.rsp_vd}), 32'({1'b1, 2'b10, 5'd9}));
        check("t4_abort_resp", 32'(unit_abort), 32'd0);
        step();
        check("t4_idle", 32'({busy, dec.rsp_valid, unit_abort}), 32'd0);

        // 5: load done ignored while a store is active
        send(4'd7, 3'd0, 3'b000, 5'd0, 12'h200, 5'd10);
        step();
        check("t5_st_start", 32'(st_start), 32'd1);
        step();
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        check("t5_ignored", 32'(dec.rsp_valid), 32'd0);
        check("t5_mem_we", 32'(mem_we), 32'd1);
        st_done = 1'b1;
        step();
        st_done = 1'b0;
        check("t5_rsp", 32'({dec.rsp_valid, dec.rsp_err, dec.rsp_vd}), 32'({1'b1, 2'b00, 5'd10}));
        step();
        check("t5_one_rsp_a", 32'(dec.rsp_valid), 32'd0);
        step();
        check("t5_one_rsp_b", 32'(dec.rsp_valid), 32'd0);

        // 6: reset during WAIT, then a normal op
        send(4'd1, 3'd0, 3'b000, 5'd0, 12'h300, 5'd11);
        step();
        step();
        step();
        check("t6_pre_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        check("t6_rst_ready", 32'(dec.req_ready), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_outs", 32'({ld_start, st_start, unit_abort, mem_sel, mem_we, dec.rsp_valid}), 32'd0);
        check("t6_rst_unit", 32'({unit_op, unit_addr}), 32'd0);
        step();
        check("t6_rst_no_abort", 32'({unit_abort, dec.rsp_valid}), 32'd0);
        nrst = 1'b1;
        step();
        send(4'd2, 3'd3, 3'b001, 5'd0, 12'h004, 5'd12);
        step();
        check("t6_ld_start", 32'(ld_start), 32'd1);
        check("t6_unit_lmul", 32'(unit_lmul), 32'd3);
        check("t6_unit_vsew", 32'(unit_vsew), 32'd1);
        step();
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
        check("t6_rsp", 32'({dec.rsp_valid, dec.rsp_err, dec.rsp_vd}), 32'({1'b1, 2'b00, 5'd12}));
        step();
        check("t6_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
